mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//   Sole owner of the CPU's external memory/DMA request port (mem_address, op). Arbitrates line
//   requests from Fetch (instruction refill) and the Memory stage (FFT/data line read or write),
//   sequences one host transaction at a time and routes returned 512-bit lines to the requester.
//   Its busy output feeds the pipeline stall.
// PARAMETERS
//   ADDRW          32    address width
//   INW            512   line / common data bus width
//   TIMEOUT_CYCLES 1024  max cycles in WAIT before abort (>=2)
// PORTS
//   clk                 in   1      clock, all state updates on posedge
//   rst_n               in   1      asynchronous, active-low reset
//   if_req              in   1      Fetch requests line read at if_addr (level, held until if_fill)
//   if_addr             in   ADDRW  Fetch line address
//   dm_req              in   1      Memory stage requests a transaction (level, held until done)
//   dm_wr               in   1      1 = write dm_wdata to dm_addr, 0 = read line
//   dm_addr             in   ADDRW  Memory stage address
//   dm_wdata            in   INW    Memory stage write line
//   dma_ready           in   1      host accepts the presented request this cycle
//   rd_valid            in   1      common_data_bus_in holds read data this cycle
//   tx_done             in   1      host completed the outstanding write
//   common_data_bus_in  in   INW    host read data
//   mem_address         out  ADDRW  request address to host
//   op                  out  2      00 none, 01 read, 10 write, 11 unused
//   wr_data_out         out  INW    write line to host
//   line_out            out  INW    registered returned line
//   instr_write_en      out  1      1-cycle pulse: line_out valid for Fetch
//   mem_write_en        out  1      1-cycle pulse: line_out valid for Memory
//   dm_wr_done          out  1      1-cycle pulse: Memory stage write complete
//   busy                out  1      state != IDLE
//   timeout             out  1      sticky: a transaction was aborted
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0 (op=00, addresses/data lines 0); last_grant=FETCH; timer=0.
//   States IDLE -> REQ -> WAIT -> DONE -> IDLE; one transaction outstanding at most.
//   IDLE: no request -> stay. Grant: only one requester -> it; both -> the one NOT in last_grant
//     (after reset data wins). Latch grant, address, dm_wr, dm_wdata; update last_grant; -> REQ.
//   REQ: mem_address = latched addr; op = 01 (read) or 10 (write); wr_data_out = latched line on
//     write. Hold until dma_ready sampled 1, then -> WAIT. All outputs registered.
//   WAIT: op=00, mem_address holds. Read: rd_valid -> line_out <= common_data_bus_in, -> DONE.
//     Write: tx_done -> DONE. Wrong-kind or stray rd_valid/tx_done (any other state) ignored.
//     Timer counts from 0 on WAIT entry; reaching TIMEOUT_CYCLES-1 without completion ->
//     timeout<=1, -> IDLE, no completion pulse.
//   DONE: exactly one of instr_write_en / mem_write_en / dm_wr_done high for this cycle; line_out
//     stable; -> IDLE. Requests ignored in DONE (requester drops req on its pulse).
//   Latency: req in IDLE at cycle 0 -> op valid cycle 1; dma_ready cycle n -> WAIT n+1;
//     rd_valid/tx_done cycle k -> pulse at k+1; next grant evaluated earliest at k+2.
//   Requester dropping req after grant: transaction still completes and pulses (no cancel).
//   rd_valid and tx_done same cycle: only the one matching latched kind acts.
//   timeout cleared only by reset. Reset mid-transaction: immediate return to reset state.
//   busy is registered from state; high from cycle after grant through DONE.
// TESTING
//   1. if_req, if_addr=0x40, dma_ready=1, rd_valid 3 cyc later data=A -> op=01 addr 0x40 one cycle,
//      instr_write_en one pulse, line_out=A.
//   2. dm_req+dm_wr, dm_addr=0x100, dm_wdata=W, dma_ready delayed 4 cyc -> op=10 held 5 cyc,
//      wr_data_out=W, tx_done -> dm_wr_done pulse; mem_write_en stays 0.
//   3. if_req and dm_req both held from reset -> grants alternate D,I,D,I; no requester starves.
//   4. Read with rd_valid never asserted -> timeout=1 after TIMEOUT_CYCLES in WAIT, no pulse,
//      busy drops, following if_req served normally.
//   5. Stray rd_valid/tx_done in IDLE and REQ -> no state change, no pulses.
//   6. rst_n low while in WAIT -> outputs 0 asynchronously; post-reset first grant goes to data.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Owns the host memory/DMA request port. Arbitrates line requests from
//   Fetch (instruction refill, always a read) and the Memory stage (line read
//   or write), runs one host transaction at a time and steers the returned
//   line to the requester with a single-cycle completion pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no transaction; evaluate requests, grant one, latch its command
//   REQ     | command presented on op/mem_address until the host takes it
//   WAIT    | host owns the transaction; wait for read data or write done
//   DONE    | one-cycle completion pulse to the granted requester
//
//   Every output is a register. The always_comb block computes the next
//   value of every register; the always_ff block only stores them.
module mem_bus_arbiter #(
    parameter int ADDRW          = 32,
    parameter int INW            = 512,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_req,
    input  logic [ADDRW-1:0] if_addr,
    input  logic             dm_req,
    input  logic             dm_wr,
    input  logic [ADDRW-1:0] dm_addr,
    input  logic [INW-1:0]   dm_wdata,
    input  logic             dma_ready,
    input  logic             rd_valid,
    input  logic             tx_done,
    input  logic [INW-1:0]   common_data_bus_in,
    output logic [ADDRW-1:0] mem_address,
    output logic [1:0]       op,
    output logic [INW-1:0]   wr_data_out,
    output logic [INW-1:0]   line_out,
    output logic             instr_write_en,
    output logic             mem_write_en,
    output logic             dm_wr_done,
    output logic             busy,
    output logic             timeout
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_t;

    state_t           state_q, state_d;
    grant_t           grant_q, grant_d;
    grant_t           last_grant_q, last_grant_d;
    logic             wr_q, wr_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [ADDRW-1:0] mem_address_d;
    logic [1:0]       op_d;
    logic [INW-1:0]   wr_data_out_d;
    logic [INW-1:0]   line_out_d;
    logic             instr_write_en_d;
    logic             mem_write_en_d;
    logic             dm_wr_done_d;
    logic             busy_d;
    logic             timeout_d;
    logic             pick_data;

    // Next-state and next-output computation for the transaction sequencer.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        wr_d             = wr_q;
        timer_d          = timer_q;
        mem_address_d    = mem_address;
        op_d             = op;
        wr_data_out_d    = wr_data_out;
        line_out_d       = line_out;
        instr_write_en_d = 1'b0;
        mem_write_en_d   = 1'b0;
        dm_wr_done_d     = 1'b0;
        timeout_d        = timeout;
        pick_data        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    // On contention the requester that did not win last time
                    // goes first, so neither side can be starved.
                    pick_data = dm_req && (!if_req || (last_grant_q == GNT_FETCH));
                    if (pick_data) begin
                        grant_d       = GNT_DATA;
                        last_grant_d  = GNT_DATA;
                        wr_d          = dm_wr;
                        mem_address_d = dm_addr;
                        op_d          = dm_wr ? OP_WRITE : OP_READ;
                        if (dm_wr) begin
                            wr_data_out_d = dm_wdata;
                        end
                    end else begin
                        grant_d       = GNT_FETCH;
                        last_grant_d  = GNT_FETCH;
                        wr_d          = 1'b0;
                        mem_address_d = if_addr;
                        op_d          = OP_READ;
                    end
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                if (dma_ready) begin
                    op_d    = OP_NONE;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Only the completion matching the latched kind counts; the
                // other strobe is ignored even if it arrives the same cycle.
                if (!wr_q && rd_valid) begin
                    line_out_d = common_data_bus_in;
                    if (grant_q == GNT_FETCH) begin
                        instr_write_en_d = 1'b1;
                    end else begin
                        mem_write_en_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end else if (wr_q && tx_done) begin
                    dm_wr_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset returns everything to idle/zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            grant_q        <= GNT_FETCH;
            last_grant_q   <= GNT_FETCH;
            wr_q           <= 1'b0;
            timer_q        <= '0;
            mem_address    <= '0;
            op             <= OP_NONE;
            wr_data_out    <= '0;
            line_out       <= '0;
            instr_write_en <= 1'b0;
            mem_write_en   <= 1'b0;
            dm_wr_done     <= 1'b0;
            busy           <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            wr_q           <= wr_d;
            timer_q        <= timer_d;
            mem_address    <= mem_address_d;
            op             <= op_d;
            wr_data_out    <= wr_data_out_d;
            line_out       <= line_out_d;
            instr_write_en <= instr_write_en_d;
            mem_write_en   <= mem_write_en_d;
            dm_wr_done     <= dm_wr_done_d;
            busy           <= busy_d;
            timeout        <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Two requester agents and a host agent drive randomized traffic. The
//   reference model works per transaction: it decides the winner from the
//   alternation rule, then predicts op/address/pulses for each cycle from the
//   host timing the bench itself chose.
module tb_mem_bus_arbiter;

    localparam int ADDRW = 32;
    localparam int INW   = 512;
    localparam int TMO   = 16;

    typedef logic [INW-1:0] word_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_req;
    logic [ADDRW-1:0] if_addr;
    logic             dm_req;
    logic             dm_wr;
    logic [ADDRW-1:0] dm_addr;
    logic [INW-1:0]   dm_wdata;
    logic             dma_ready;
    logic             rd_valid;
    logic             tx_done;
    logic [INW-1:0]   common_data_bus_in;
    logic [ADDRW-1:0] mem_address;
    logic [1:0]       op;
    logic [INW-1:0]   wr_data_out;
    logic [INW-1:0]   line_out;
    logic             instr_write_en;
    logic             mem_write_en;
    logic             dm_wr_done;
    logic             busy;
    logic             timeout;

    mem_bus_arbiter #(
        .ADDRW          (ADDRW),
        .INW            (INW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .if_req             (if_req),
        .if_addr            (if_addr),
        .dm_req             (dm_req),
        .dm_wr              (dm_wr),
        .dm_addr            (dm_addr),
        .dm_wdata           (dm_wdata),
        .dma_ready          (dma_ready),
        .rd_valid           (rd_valid),
        .tx_done            (tx_done),
        .common_data_bus_in (common_data_bus_in),
        .mem_address        (mem_address),
        .op                 (op),
        .wr_data_out        (wr_data_out),
        .line_out           (line_out),
        .instr_write_en     (instr_write_en),
        .mem_write_en       (mem_write_en),
        .dm_wr_done         (dm_wr_done),
        .busy               (busy),
        .timeout            (timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit               last_dm_m;
    bit               tmo_m;
    word_t            line_m;
    logic [ADDRW-1:0] addr_m;

    task automatic check_val(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic word_t rnd_line();
        word_t r;
        for (int i = 0; i < INW / 32; i++) begin
            r[i*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    function automatic bit coin(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string ph, input bit b, input logic [1:0] o,
                               input logic [ADDRW-1:0] a, input bit iw, input bit mw,
                               input bit dw);
        check_val({ph, " busy"}, word_t'(busy), word_t'(b));
        check_val({ph, " op"}, word_t'(op), word_t'(o));
        check_val({ph, " mem_address"}, word_t'(mem_address), word_t'(a));
        check_val({ph, " instr_write_en"}, word_t'(instr_write_en), word_t'(iw));
        check_val({ph, " mem_write_en"}, word_t'(mem_write_en), word_t'(mw));
        check_val({ph, " dm_wr_done"}, word_t'(dm_wr_done), word_t'(dw));
        check_val({ph, " timeout"}, word_t'(timeout), word_t'(tmo_m));
        check_val({ph, " line_out"}, line_out, line_m);
    endtask

    task automatic check_reset_outs(input string ph);
        check_val({ph, " busy"}, word_t'(busy), '0);
        check_val({ph, " op"}, word_t'(op), '0);
        check_val({ph, " mem_address"}, word_t'(mem_address), '0);
        check_val({ph, " wr_data_out"}, wr_data_out, '0);
        check_val({ph, " line_out"}, line_out, '0);
        check_val({ph, " pulses"}, word_t'({instr_write_en, mem_write_en, dm_wr_done}), '0);
        check_val({ph, " timeout"}, word_t'(timeout), '0);
    endtask

    task automatic model_reset();
        last_dm_m = 1'b0;
        tmo_m     = 1'b0;
        line_m    = '0;
        addr_m    = '0;
    endtask

    task automatic strays(input bit allow_rd, input bit allow_tx);
        rd_valid           = allow_rd && coin(50);
        tx_done            = allow_tx && coin(50);
        common_data_bus_in = rnd_line();
    endtask

    // One host transaction, starting #1 into an IDLE cycle.
    // mode 0: random, 1: host never completes (timeout), 2: reset during WAIT.
    task automatic do_txn(input bit both, input int mode);
        bit               win_dm;
        bit               is_wr;
        bit               tmo;
        logic [ADDRW-1:0] a;
        word_t            wd;
        word_t            rd;
        int               rdly;
        int               wdly;
        int               nwait;

        if (!if_req && !dm_req && !both && mode == 0 && coin(25)) begin
            for (int g = 0; g < 3; g++) begin
                expect_outs("idle gap", 1'b0, 2'b00, addr_m, 1'b0, 1'b0, 1'b0);
                dma_ready = coin(50);
                strays(1'b1, 1'b1);
                tick();
            end
        end

        if (!if_req && (both || coin(75))) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFE;
        end
        if (!dm_req && (both || coin(75))) begin
            dm_req   = 1'b1;
            dm_wr    = coin(50);
            dm_addr  = $urandom | 32'h1;
            dm_wdata = rnd_line();
        end
        if (!if_req && !dm_req) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFE;
        end

        expect_outs("idle", 1'b0, 2'b00, addr_m, 1'b0, 1'b0, 1'b0);
        dma_ready = coin(50);
        strays(1'b1, 1'b1);

        win_dm    = (if_req && dm_req) ? !last_dm_m : dm_req;
        last_dm_m = win_dm;
        is_wr     = win_dm && dm_wr;
        a         = win_dm ? dm_addr : if_addr;
        wd        = dm_wdata;
        addr_m    = a;
        tick();

        rdly = $urandom_range(0, 4);
        for (int i = 0; i <= rdly; i++) begin
            expect_outs("req", 1'b1, is_wr ? 2'b10 : 2'b01, a, 1'b0, 1'b0, 1'b0);
            if (is_wr) begin
                check_val("req wr_data_out", wr_data_out, wd);
            end
            dma_ready = (i == rdly);
            strays(1'b1, 1'b1);
            if (coin(12)) begin
                if (win_dm) dm_req = 1'b0;
                else        if_req = 1'b0;
            end
            tick();
        end

        tmo   = (mode != 0) || coin(10);
        wdly  = $urandom_range(0, 5);
        nwait = tmo ? TMO : wdly + 1;
        rd    = '0;
        for (int j = 0; j < nwait; j++) begin
            expect_outs("wait", 1'b1, 2'b00, a, 1'b0, 1'b0, 1'b0);
            if (mode == 2 && j == 2) begin
                #2;
                rst_n     = 1'b0;
                if_req    = 1'b0;
                dm_req    = 1'b0;
                rd_valid  = 1'b0;
                tx_done   = 1'b0;
                dma_ready = 1'b0;
                #1;
                model_reset();
                check_reset_outs("async reset");
                tick();
                rst_n = 1'b1;
                return;
            end
            dma_ready = coin(50);
            if (!tmo && j == wdly) begin
                strays(1'b1, 1'b1);
                if (is_wr) tx_done = 1'b1;
                else       rd_valid = 1'b1;
                rd = common_data_bus_in;
            end else begin
                strays(is_wr, !is_wr);
            end
            tick();
        end

        rd_valid = 1'b0;
        tx_done  = 1'b0;
        if (tmo) begin
            tmo_m = 1'b1;
            return;
        end

        if (!is_wr) line_m = rd;
        expect_outs("done", 1'b1, 2'b00, a, !win_dm, win_dm && !is_wr, is_wr);
        if (win_dm) dm_req = 1'b0;
        else        if_req = 1'b0;
        strays(1'b1, 1'b1);
        tick();
        rd_valid = 1'b0;
        tx_done  = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        if_req             = 1'b0;
        if_addr            = '0;
        dm_req             = 1'b0;
        dm_wr              = 1'b0;
        dm_addr            = '0;
        dm_wdata           = '0;
        dma_ready          = 1'b0;
        rd_valid           = 1'b0;
        tx_done            = 1'b0;
        common_data_bus_in = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) do_txn(1'b1, 0);
        for (int t = 0; t < 40; t++) do_txn(coin(30), 0);
        do_txn(1'b0, 1);
        for (int t = 0; t < 6; t++) do_txn(1'b0, 0);
        do_txn(1'b0, 2);
        for (int t = 0; t < 6; t++) do_txn(1'b1, 0);
        for (int t = 0; t < 40; t++) do_txn(coin(30), 0);
        do_txn(1'b1, 1);
        for (int t = 0; t < 4; t++) do_txn(1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
